if_stage_unit: RTL
==================

// Module: if_stage_unit
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, drives the PC to the
//  instruction memory, receives its combinational instruction word and registers it into the IF/ID
//  pipeline register. Handles hazard freeze (stall) and branch/jump redirect with IF/ID flush.
// PARAMETERS
//  n          32            datapath / address width in bits
//  RESET_PC   32'h00000000  PC value loaded on reset
// PORTS
//  clk              in   1   single system clock; all state updates on posedge clk
//  rst              in   1   synchronous, active-high reset; sampled on posedge clk
//  freeze           in   1   hazard-unit stall: hold PC and IF/ID contents
//  branch_taken     in   1   redirect request from the branch-resolution stage
//  branch_addr      in   n   redirect target (byte address)
//  pc_out           out  n   current PC, to instruction memory PC input (combinational from pc_q)
//  instruction_in   in   n   instruction word read from instruction memory at pc_out, same cycle
//  if_id_pc         out  n   registered PC+4 of the fetched instruction
//  if_id_instr      out  n   registered instruction word (32'b0 = NOP/bubble)
//  if_id_valid      out  1   1 = if_id_instr is a real fetched instruction, 0 = bubble
//  fetch_count      out  32  fetched-instruction counter (see CONFIGURATION)
//  stall_count      out  32  frozen-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): pc_q<=RESET_PC; if_id_pc<=0; if_id_instr<=0; if_id_valid<=0;
//    counters<=0. rst overrides every other input, including mid-freeze or mid-redirect.
//  - Priority per posedge (rst low): branch_taken > freeze > normal advance.
//  - Normal (branch_taken=0, freeze=0): pc_q<=pc_q+4; if_id_pc<=pc_q+4; if_id_instr<=instruction_in;
//    if_id_valid<=1. Fetch latency: instruction at pc_out appears on if_id_instr 1 cycle later.
//  - Freeze (branch_taken=0, freeze=1): pc_q, if_id_pc, if_id_instr, if_id_valid all hold.
//  - Redirect (branch_taken=1, freeze ignored): pc_q<={branch_addr[n-1:2],2'b00}; if_id_instr<=0;
//    if_id_pc<=0; if_id_valid<=0 (flush the wrong-path instruction fetched this cycle). The target
//    instruction is fetched the following cycle; one bubble per taken branch.
//  - PC arithmetic is unsigned modulo 2^n: pc_q=2^n-4 advances to 0. pc_q[1:0] is always 2'b00.
//  - pc_out = pc_q continuously; no combinational path from freeze/branch inputs to pc_out.
//  - An all-zero instruction_in is registered like any other word with if_id_valid=1; downstream
//    decodes it as NOP.
//  - No outputs are X after the first reset; inputs before first reset are don't-care.
// CONFIGURATION
//  IF_PERF_CNT_EN defined:
//   - fetch_count increments on every normal-advance cycle; stall_count on every freeze cycle
//     with branch_taken=0. Both saturate at 32'hFFFFFFFF; both cleared by rst.
//  IF_PERF_CNT_EN undefined:
//   - counter logic omitted; fetch_count and stall_count tied to 32'b0; ports still exist.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> pc_out=0, if_id_instr=0, if_id_pc=0, if_id_valid=0.
//  2 Advance: release rst, instruction_in=32'h8020000A at pc 0 -> next cycle if_id_instr=32'h8020000A,
//    if_id_pc=4, if_id_valid=1, pc_out=4; then pc_out=8, 12 on successive cycles.
//  3 Freeze: freeze=1 for 2 cycles at pc_out=8 -> pc_out stays 8, IF/ID unchanged; release ->
//    pc_out=12 next cycle; with IF_PERF_CNT_EN stall_count=2.
//  4 Redirect+freeze: branch_taken=1, freeze=1, branch_addr=32'h43 at pc_out=12 -> pc_out=32'h40,
//    if_id_instr=0, if_id_valid=0; next cycle fetches from 32'h40, if_id_pc=32'h44.
//  5 Wrap: branch_addr=32'hFFFFFFFC -> pc_out=32'hFFFFFFFC, then pc_out=0, if_id_pc=0, valid=1.
//  6 Reset mid-freeze: freeze=1 and rst=1 at pc_out=32'h20 -> pc_out=0, IF/ID cleared, counters=0.

Source files
------------

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall hold and branch redirect/flush.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage_unit #(
    parameter int unsigned    n        = 32,
    parameter logic [n-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          branch_taken,
    input  logic [n-1:0]  branch_addr,
    output logic [n-1:0]  pc_out,
    input  logic [n-1:0]  instruction_in,
    output logic [n-1:0]  if_id_pc,
    output logic [n-1:0]  if_id_instr,
    output logic          if_id_valid,
    output logic [31:0]   fetch_count,
    output logic [31:0]   stall_count
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_FREEZE   = 2'd1,
        ACT_REDIRECT = 2'd2
    } act_t;

    logic [n-1:0] r_pc;
    logic [n-1:0] r_if_id_pc;
    logic [n-1:0] r_if_id_instr;
    logic         r_if_id_valid;

    act_t         w_act;
    logic [n-1:0] w_pc_plus4;
    logic [n-1:0] w_target;
    logic [n-1:0] w_pc_nxt;
    logic [n-1:0] w_if_id_pc_nxt;
    logic [n-1:0] w_if_id_instr_nxt;
    logic         w_if_id_valid_nxt;

    assign w_pc_plus4 = r_pc + n'(4);
    // Low two target bits are forced to zero so the PC stays word aligned.
    assign w_target   = branch_addr & ~n'(3);

    // Redirect outranks freeze, freeze outranks normal advance.
    always_comb begin
        w_act = ACT_ADVANCE;
        if (branch_taken) begin
            w_act = ACT_REDIRECT;
        end else if (freeze) begin
            w_act = ACT_FREEZE;
        end
    end

    always_comb begin
        w_pc_nxt          = r_pc;
        w_if_id_pc_nxt    = r_if_id_pc;
        w_if_id_instr_nxt = r_if_id_instr;
        w_if_id_valid_nxt = r_if_id_valid;
        case (w_act)
            ACT_ADVANCE: begin
                w_pc_nxt          = w_pc_plus4;
                w_if_id_pc_nxt    = w_pc_plus4;
                w_if_id_instr_nxt = instruction_in;
                w_if_id_valid_nxt = 1'b1;
            end
            ACT_REDIRECT: begin
                w_pc_nxt          = w_target;
                w_if_id_pc_nxt    = '0;
                w_if_id_instr_nxt = '0;
                w_if_id_valid_nxt = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= '0;
            r_if_id_instr <= '0;
            r_if_id_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
        end
    end

    assign pc_out      = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] r_fetch_count;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_fetch_inc;
    logic             w_stall_inc;

    assign w_fetch_inc = (w_act == ACT_ADVANCE) && (r_fetch_count != {CNT_W{1'b1}});
    assign w_stall_inc = (w_act == ACT_FREEZE)  && (r_stall_count != {CNT_W{1'b1}});

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_fetch_inc) begin
                r_fetch_count <= r_fetch_count + CNT_W'(1);
            end
            if (w_stall_inc) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`else
    assign fetch_count = CNT_W'(0);
    assign stall_count = CNT_W'(0);
`endif

endmodule
